// File: rtl/pmem_rr_arbiter_if.sv
// Bundle of requester-side channel signals and the physical memory port
// handled by pmem_rr_arbiter; slave is the arbiter's view, master the environment's.
interface pmem_rr_arbiter_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [NUM_CH*ADDR_WIDTH-1:0] ch_address;
  logic [NUM_CH*LINE_WIDTH-1:0] ch_wdata;
  logic [NUM_CH-1:0]            ch_read;
  logic [NUM_CH-1:0]            ch_write;
  logic [LINE_WIDTH-1:0]        ch_rdata;
  logic [NUM_CH-1:0]            ch_resp;

  logic [ADDR_WIDTH-1:0]        pmem_address;
  logic [LINE_WIDTH-1:0]        pmem_wdata;
  logic                         pmem_read;
  logic                         pmem_write;
  logic [LINE_WIDTH-1:0]        pmem_rdata;
  logic                         pmem_resp;

  logic                         busy;
  logic [IDX_W-1:0]             grant_id;

  modport slave (
    input  ch_address, ch_wdata, ch_read, ch_write, pmem_rdata, pmem_resp,
    output ch_rdata, ch_resp, pmem_address, pmem_wdata, pmem_read, pmem_write,
           busy, grant_id
  );

  modport master (
    output ch_address, ch_wdata, ch_read, ch_write, pmem_rdata, pmem_resp,
    input  ch_rdata, ch_resp, pmem_address, pmem_wdata, pmem_read, pmem_write,
           busy, grant_id
  );
endinterface

// File: rtl/pmem_rr_arbiter.sv
// N-channel cache-line arbiter onto one physical memory port: round-robin or
// fixed-priority grant, registered pmem outputs and a one-cycle resp pulse.
module pmem_rr_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter bit RR_MODE    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  pmem_rr_arbiter_if.slave     arb_io
);
  localparam int IDX_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e                state_q,  state_d;
  logic [IDX_W-1:0]      ptr_q,    ptr_d;
  logic [IDX_W-1:0]      gid_q,    gid_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [LINE_WIDTH-1:0] wdata_q,  wdata_d;
  logic                  rd_q,     rd_d;
  logic                  wr_q,     wr_d;
  logic [LINE_WIDTH-1:0] rdata_q,  rdata_d;
  logic [NUM_CH-1:0]     resp_q,   resp_d;

  logic [NUM_CH-1:0]     req;
  logic [IDX_W-1:0]      win_idx;

  assign req = arb_io.ch_read | arb_io.ch_write;

  // Winner: lowest set index overall, then (round-robin only) overridden by the
  // lowest set index at or above the pointer; if none exists the search wraps.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IDX_W'(i);
    end
    if (RR_MODE) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i] && (i >= int'(ptr_q))) win_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal is defaulted to its register first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          addr_d  = arb_io.ch_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = arb_io.ch_wdata[win_idx*LINE_WIDTH +: LINE_WIDTH];
          wr_d    = arb_io.ch_write[win_idx];
          rd_d    = arb_io.ch_read[win_idx] & ~arb_io.ch_write[win_idx];
          gid_d   = win_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (arb_io.pmem_resp) begin
          rdata_d = arb_io.pmem_rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          resp_d  = NUM_CH'(1) << gid_q;
          if (RR_MODE) begin
            ptr_d = (gid_q == IDX_W'(NUM_CH - 1)) ? '0 : gid_q + IDX_W'(1);
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign arb_io.pmem_address = addr_q;
  assign arb_io.pmem_wdata   = wdata_q;
  assign arb_io.pmem_read    = rd_q;
  assign arb_io.pmem_write   = wr_q;
  assign arb_io.ch_rdata     = rdata_q;
  assign arb_io.ch_resp      = resp_q;
  assign arb_io.grant_id     = gid_q;
  assign arb_io.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// Drives a round-robin and a fixed-priority 4-channel arbiter with identical
// stimulus and compares both against a transaction-level reference model.
module tb_pmem_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 64;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_rr_arbiter_if #(.NUM_CH(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus_rr ();
  pmem_rr_arbiter_if #(.NUM_CH(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus_fx ();

  pmem_rr_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .arb_io(bus_rr.slave));
  pmem_rr_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .arb_io(bus_fx.slave));

  // Shared stimulus
  logic [N-1:0]  rd, wr;
  logic [AW-1:0] addr [N];
  logic [LW-1:0] wdat [N];
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  int            sel;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus_rr.ch_address[g*AW +: AW] = addr[g];
    assign bus_fx.ch_address[g*AW +: AW] = addr[g];
    assign bus_rr.ch_wdata[g*LW +: LW]   = wdat[g];
    assign bus_fx.ch_wdata[g*LW +: LW]   = wdat[g];
  end
  assign bus_rr.ch_read = rd;  assign bus_fx.ch_read = rd;
  assign bus_rr.ch_write = wr; assign bus_fx.ch_write = wr;
  assign bus_rr.pmem_rdata = mem_rdata; assign bus_fx.pmem_rdata = mem_rdata;
  assign bus_rr.pmem_resp = mem_resp;   assign bus_fx.pmem_resp = mem_resp;

  // Observed outputs, index 0 = round-robin DUT, 1 = fixed-priority DUT
  logic [N-1:0]  o_resp [2];
  logic          o_read [2], o_write [2], o_busy [2];
  logic [AW-1:0] o_addr [2];
  logic [LW-1:0] o_wdata [2], o_rdata [2];
  logic [IW-1:0] o_gid [2];
  assign o_resp[0] = bus_rr.ch_resp;       assign o_resp[1] = bus_fx.ch_resp;
  assign o_read[0] = bus_rr.pmem_read;     assign o_read[1] = bus_fx.pmem_read;
  assign o_write[0] = bus_rr.pmem_write;   assign o_write[1] = bus_fx.pmem_write;
  assign o_busy[0] = bus_rr.busy;          assign o_busy[1] = bus_fx.busy;
  assign o_addr[0] = bus_rr.pmem_address;  assign o_addr[1] = bus_fx.pmem_address;
  assign o_wdata[0] = bus_rr.pmem_wdata;   assign o_wdata[1] = bus_fx.pmem_wdata;
  assign o_rdata[0] = bus_rr.ch_rdata;     assign o_rdata[1] = bus_fx.ch_rdata;
  assign o_gid[0] = bus_rr.grant_id;       assign o_gid[1] = bus_fx.grant_id;

  // Transaction-level reference model
  bit            m_txn [2], m_rsp [2], m_rd [2], m_wr [2];
  int            m_gid [2], m_ptr [2];
  logic [AW-1:0] m_addr [2];
  logic [LW-1:0] m_wdata [2], m_rdata [2];
  logic [N-1:0]  m_resp [2];

  int n_cmp = 0;
  int n_bad = 0;
  int grants[$];
  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int exp_fx[2] = '{1, 2};
  bit prev_strobe;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int m, input logic [N-1:0] req);
    int base = (m == 0) ? m_ptr[m] : 0;
    for (int k = 0; k < N; k++) begin
      if (req[(base + k) % N]) return (base + k) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_txn[m] = 0; m_rsp[m] = 0; m_rd[m] = 0; m_wr[m] = 0;
      m_gid[m] = 0; m_ptr[m] = 0; m_addr[m] = '0; m_wdata[m] = '0;
      m_rdata[m] = '0; m_resp[m] = '0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (m_rsp[m]) begin
        m_rsp[m] = 0; m_resp[m] = '0;
      end else if (m_txn[m]) begin
        if (mem_resp) begin
          m_rdata[m] = mem_rdata; m_rd[m] = 0; m_wr[m] = 0;
          m_resp[m] = '0; m_resp[m][m_gid[m]] = 1'b1;
          m_txn[m] = 0; m_rsp[m] = 1;
          if (m == 0) m_ptr[m] = (m_gid[m] + 1) % N;
        end
      end else if ((rd | wr) != '0) begin
        int w = pick(m, rd | wr);
        m_txn[m] = 1; m_gid[m] = w;
        m_addr[m] = addr[w]; m_wdata[m] = wdat[w];
        m_wr[m] = wr[w]; m_rd[m] = rd[w] & ~wr[w];
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      string nm = (m == 0) ? "rr" : "fx";
      check({nm, ".pmem_read"},    64'(o_read[m]),  64'(m_rd[m]));
      check({nm, ".pmem_write"},   64'(o_write[m]), 64'(m_wr[m]));
      check({nm, ".pmem_address"}, 64'(o_addr[m]),  64'(m_addr[m]));
      check({nm, ".pmem_wdata"},   o_wdata[m],      m_wdata[m]);
      check({nm, ".ch_rdata"},     o_rdata[m],      m_rdata[m]);
      check({nm, ".ch_resp"},      64'(o_resp[m]),  64'(m_resp[m]));
      check({nm, ".busy"},         64'(o_busy[m]),  64'(m_txn[m] | m_rsp[m]));
      check({nm, ".grant_id"},     64'(o_gid[m]),   64'(m_gid[m]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
    check_all();
  endtask

  task automatic drain(input int n);
    rd = '0; wr = '0;
    repeat (n) begin
      tick();
      mem_resp = o_read[0] | o_write[0] | o_read[1] | o_write[1];
    end
    mem_resp = 1'b0;
  endtask

  task automatic new_req(input int c);
    case ($urandom_range(0, 2))
      0:       begin rd[c] = 1'b1; wr[c] = 1'b0; end
      1:       begin rd[c] = 1'b0; wr[c] = 1'b1; end
      default: begin rd[c] = 1'b1; wr[c] = 1'b1; end
    endcase
  endtask

  task automatic run_random(input int s, input int n);
    sel = s;
    repeat (n) begin
      tick();
      for (int c = 0; c < N; c++) begin
        addr[c] = $urandom;
        wdat[c] = {$urandom, $urandom};
        if (o_resp[sel][c]) begin
          if ($urandom_range(0, 1) == 0) begin rd[c] = 1'b0; wr[c] = 1'b0; end
          else new_req(c);
        end else if (rd[c] | wr[c]) begin
          if ($urandom_range(0, 19) == 0) begin rd[c] = 1'b0; wr[c] = 1'b0; end
        end else if ($urandom_range(0, 3) == 0) begin
          new_req(c);
        end
      end
      mem_resp  = (o_read[sel] | o_write[sel]) ? ($urandom_range(0, 2) == 0)
                                               : ($urandom_range(0, 7) == 0);
      mem_rdata = {$urandom, $urandom};
    end
    drain(8);
  endtask

  task automatic collect_grants(input int s, input int want, input bit drop_on_resp);
    grants.delete();
    prev_strobe = 1'b0;
    for (int t = 0; t < 80 && grants.size() < want; t++) begin
      tick();
      if (o_read[s] | o_write[s]) begin
        if (!prev_strobe) grants.push_back(int'(o_gid[s]));
        prev_strobe = 1'b1;
      end else begin
        prev_strobe = 1'b0;
      end
      if (drop_on_resp) rd = rd & ~o_resp[s];
      mem_resp = o_read[s] | o_write[s];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rd = '0; wr = '0; mem_resp = 1'b0; mem_rdata = '0; sel = 0;
    for (int c = 0; c < N; c++) begin addr[c] = '0; wdat[c] = '0; end
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b1;

    // Round-robin contention with all channels held: 0,1,2,3 then wrap to 0
    rd = '1;
    collect_grants(0, 5, 1'b0);
    check("rr.grant_count", 64'(grants.size()), 64'd5);
    for (int i = 0; i < grants.size() && i < 5; i++)
      check($sformatf("rr.grant_order[%0d]", i), 64'(grants[i]), 64'(exp_rr[i]));
    drain(8);

    // Single read: strobe cycles 1-4, resp in cycle 4, ch_resp in cycle 5
    rd = 4'b0001; addr[0] = 32'h100;
    tick();
    check("single.read_c1", 64'(o_read[0]), 64'd1);
    check("single.addr_c1", 64'(o_addr[0]), 64'h100);
    addr[0] = 32'hBAD;
    tick(); tick(); tick();
    check("single.read_c4", 64'(o_read[0]), 64'd1);
    check("single.addr_held", 64'(o_addr[0]), 64'h100);
    mem_resp = 1'b1; mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    tick();
    check("single.resp_c5", 64'(o_resp[0]), 64'b0001);
    check("single.rdata_c5", o_rdata[0], 64'hA5A5_A5A5_A5A5_A5A5);
    check("single.read_c5", 64'(o_read[0]), 64'd0);
    rd = '0; mem_resp = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("single.no_regrant", 64'(o_read[0]), 64'd0);
    check("single.rdata_hold", o_rdata[0], 64'hA5A5_A5A5_A5A5_A5A5);
    drain(4);

    // Read and write together on one channel: write wins
    rd = 4'b0001; wr = 4'b0001; wdat[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    check("rw.pmem_write", 64'(o_write[0]), 64'd1);
    check("rw.pmem_read", 64'(o_read[0]), 64'd0);
    check("rw.pmem_wdata", o_wdata[0], 64'hDEAD_BEEF_DEAD_BEEF);
    mem_resp = 1'b1;
    tick();
    check("rw.resp", 64'(o_resp[0]), 64'b0001);
    drain(4);

    // Withdrawal in ISSUE plus late arrival on ch1
    rd = 4'b0001;
    tick();
    rd = 4'b0010;
    tick();
    mem_resp = 1'b1;
    tick();
    check("wd.resp_still", 64'(o_resp[0]), 64'b0001);
    mem_resp = 1'b0;
    tick();
    check("wd.idle_gap", 64'(o_read[0]), 64'd0);
    tick();
    check("wd.ch1_read", 64'(o_read[0]), 64'd1);
    check("wd.ch1_gid", 64'(o_gid[0]), 64'd1);
    mem_resp = 1'b1;
    tick();
    drain(6);

    // Asynchronous reset mid-ISSUE
    rd = 4'b0100;
    tick(); tick();
    check("rst.pre_read", 64'(o_read[0]), 64'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst.pmem_read", 64'(o_read[0]), 64'd0);
    check("rst.ch_resp", 64'(o_resp[0]), 64'd0);
    check("rst.grant_id", 64'(o_gid[0]), 64'd0);
    check_all();
    rd = '0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst.grant_after", 64'(o_gid[0]), 64'd0);
    @(negedge clk);
    model_step();
    check_all();

    // Fixed priority: ch1 before ch2
    rd = 4'b0110;
    collect_grants(1, 2, 1'b1);
    check("fx.grant_count", 64'(grants.size()), 64'd2);
    for (int i = 0; i < grants.size() && i < 2; i++)
      check($sformatf("fx.grant_order[%0d]", i), 64'(grants[i]), 64'(exp_fx[i]));
    drain(8);

    run_random(0, 1500);
    run_random(1, 1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
